lut_sweep: RTL and testbench

Parametrised, programmable N-input Boolean function unit that generalises the team's fixed 4-input SOP/POS function blocks. It holds a 2^N-bit truth table (reset to INIT, reloadable at run time), evaluates it for a live input vector with one-cycle registered latency, and on request sweeps the table. During a sweep it streams the minterm indices, the maxterm indices or all rows over a valid/ready handshake, then reports how many rows it emitted. It sits beside the combinational function blocks as their self-checking, reprogrammable replacement.

---
 rtl/lut_sweep_pkg.sv | 26 ++
 rtl/lut_sweep_if.sv | 33 +++
 rtl/lut_sweep_qualify.sv | 28 ++
 rtl/lut_sweep.sv | 146 ++++++++++++++
 tb/tb_lut_sweep.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lut_sweep_pkg.sv
// Shared types and constants for the programmable truth-table unit.
// FSM state encoding, sweep filter codes and the row filter.
package lut_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_ALL = 2'b00;
   localparam logic [1:0] MODE_MIN = 2'b01;
   localparam logic [1:0] MODE_MAX = 2'b10;

   // Mode 11 falls into the default branch and behaves like MODE_ALL.
   function automatic logic row_qualifies(input logic f, input logic [1:0] mode);
      logic q;
      case (mode)
         MODE_MIN: q = f;
         MODE_MAX: q = ~f;
         default:  q = 1'b1;
      endcase
      return q;
   endfunction

endpackage

// File: rtl/lut_sweep_if.sv
// Load, eval, sweep-control and row-stream signals of lut_sweep.
// master drives the requests, slave is the unit itself.
interface lut_sweep_if #(parameter int N = 4);

   logic                  load_valid;
   logic [(1<<N)-1:0]     load_data;
   logic                  load_ready;
   logic [N-1:0]          eval_in;
   logic                  eval_out;
   logic                  start;
   logic [1:0]            mode;
   logic                  busy;
   logic                  out_valid;
   logic                  out_ready;
   logic [N-1:0]          out_index;
   logic                  out_value;
   logic                  out_last;
   logic                  done;
   logic [N:0]            count;

   modport master (
      output load_valid, load_data, eval_in, start, mode, out_ready,
      input  load_ready, eval_out, busy, out_valid, out_index, out_value,
             out_last, done, count
   );

   modport slave (
      input  load_valid, load_data, eval_in, start, mode, out_ready,
      output load_ready, eval_out, busy, out_valid, out_index, out_value,
             out_last, done, count
   );

endinterface

// File: rtl/lut_sweep_qualify.sv
// Combinational row filter: does row idx qualify, and does any
// qualifying row exist above it (used to flag the last emitted row).
module lut_qualify
   import lut_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [(1<<N)-1:0] tt_i,
   input  logic [1:0]        mode_i,
   input  logic [N-1:0]      idx_i,
   output logic              qual_o,
   output logic              above_o
);

   // Priority-free OR over all rows strictly above idx_i.
   always_comb begin
      qual_o  = row_qualifies(tt_i[idx_i], mode_i);
      above_o = 1'b0;
      for (int k = 0; k < (1 << N); k++) begin
         if ((k > int'(idx_i)) && row_qualifies(tt_i[k], mode_i)) begin
            above_o = 1'b1;
         end else begin
            above_o = above_o;
         end
      end
   end

endmodule

// File: rtl/lut_sweep.sv
// Programmable N-input truth table with registered evaluation and a
// filtered row sweep streamed over a valid/ready output slot.
module lut_sweep
   import lut_pkg::*;
#(
   parameter int              N    = 4,
   parameter logic [(1<<N)-1:0] INIT = 16'h212F
) (
   input  logic       clk,
   input  logic       rst,
   lut_sweep_if.slave bus
);

   state_t            state_q, state_d;
   logic [(1<<N)-1:0] tt_q, tt_d;
   logic [N:0]        idx_q, idx_d;
   logic [N:0]        cnt_q, cnt_d;
   logic [N:0]        count_q, count_d;
   logic [1:0]        mode_q, mode_d;
   logic              valid_q, valid_d;
   logic [N-1:0]      index_q, index_d;
   logic              value_q, value_d;
   logic              last_q, last_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              load_ready_q, load_ready_d;
   logic              eval_q;
   logic              qual_s, above_s, take_s, load_acc_s;

   lut_qualify #(.N(N)) u_qualify (
      .tt_i    (tt_q),
      .mode_i  (mode_q),
      .idx_i   (idx_q[N-1:0]),
      .qual_o  (qual_s),
      .above_o (above_s)
   );

   assign load_acc_s = bus.load_valid & load_ready_q;
   assign take_s     = ~valid_q | bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         tt_q         <= INIT;
         idx_q        <= '0;
         cnt_q        <= '0;
         count_q      <= '0;
         mode_q       <= MODE_ALL;
         valid_q      <= 1'b0;
         index_q      <= '0;
         value_q      <= 1'b0;
         last_q       <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         load_ready_q <= 1'b0;
         eval_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tt_q         <= tt_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         count_q      <= count_d;
         mode_q       <= mode_d;
         valid_q      <= valid_d;
         index_q      <= index_d;
         value_q      <= value_d;
         last_q       <= last_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         load_ready_q <= load_ready_d;
         // Reads the pre-load table when a load lands on the same edge.
         eval_q       <= tt_q[bus.eval_in];
      end
   end

   // idx is N+1 bits wide so it parks at 2^N once every row is scanned.
   always_comb begin
      state_d = state_q;
      tt_d    = tt_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      count_d = count_q;
      mode_d  = mode_q;
      valid_d = valid_q;
      index_d = index_q;
      value_d = value_q;
      last_d  = last_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_acc_s) begin
               tt_d = bus.load_data;
            end else if (bus.start) begin
               mode_d  = bus.mode;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = SWEEP;
            end else begin
               state_d = IDLE;
            end
         end
         SWEEP: begin
            if (take_s) begin
               if (!idx_q[N]) begin
                  idx_d = idx_q + {{N{1'b0}}, 1'b1};
                  if (qual_s) begin
                     valid_d = 1'b1;
                     index_d = idx_q[N-1:0];
                     value_d = tt_q[idx_q[N-1:0]];
                     last_d  = ~above_s;
                     cnt_d   = cnt_q + {{N{1'b0}}, 1'b1};
                  end else begin
                     valid_d = 1'b0;
                  end
               end else begin
                  valid_d = 1'b0;
                  count_d = cnt_q;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end else begin
               state_d = SWEEP;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d       = (state_d != IDLE);
      load_ready_d = (state_d == IDLE);
   end

   assign bus.load_ready = load_ready_q;
   assign bus.eval_out   = eval_q;
   assign bus.busy       = busy_q;
   assign bus.out_valid  = valid_q;
   assign bus.out_index  = index_q;
   assign bus.out_value  = value_q;
   assign bus.out_last   = last_q;
   assign bus.done       = done_q;
   assign bus.count      = count_q;

endmodule

// File: tb/tb_lut_sweep.sv
// Scoreboard bench for lut_sweep: expected rows are queued at sweep start
// and popped as the output slot is accepted.
module tb_lut_sweep;

   localparam int          N    = 4;
   localparam logic [15:0] INIT = 16'h212F;

   typedef struct packed {
      logic [3:0] idx;
      logic       val;
      logic       last;
   } row_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lut_sweep_if #(.N(N)) bus ();

   lut_sweep #(.N(N), .INIT(INIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   row_t        sq[$];
   row_t        held;
   row_t        e;
   logic [15:0] model;
   int          n_checks   = 0;
   int          n_fail     = 0;
   int          rows_seen  = 0;
   int          stall_cnt  = 0;
   bit          stall_en   = 1'b0;
   bit          prev_stall = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit tb_qual(input logic f, input logic [1:0] m);
      if (m == 2'b01) return f;
      if (m == 2'b10) return ~f;
      return 1'b1;
   endfunction

   // Output consumer: decides out_ready, checks held rows and pops the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         bus.out_ready = 1'b1;
         prev_stall    = 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold_index", 32'(bus.out_index), 32'(held.idx));
            check_eq("hold_value", 32'(bus.out_value), 32'(held.val));
            check_eq("hold_last",  32'(bus.out_last),  32'(held.last));
         end
         if (stall_en && bus.out_valid && bus.out_index == 4'd5 && stall_cnt < 3) begin
            bus.out_ready = 1'b0;
            stall_cnt++;
         end else begin
            bus.out_ready = 1'b1;
         end
         if (bus.out_valid && !bus.out_ready) begin
            prev_stall = 1'b1;
            held       = '{idx: bus.out_index, val: bus.out_value, last: bus.out_last};
         end else begin
            prev_stall = 1'b0;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sq.size() == 0) begin
               check_eq("unexpected_row", 32'(bus.out_index), 32'hFFFF_FFFF);
            end else begin
               e = sq.pop_front();
               check_eq("row_index", 32'(bus.out_index), 32'(e.idx));
               check_eq("row_value", 32'(bus.out_value), 32'(e.val));
               check_eq("row_last",  32'(bus.out_last),  32'(e.last));
            end
            rows_seen++;
         end
      end
   end

   task automatic push_rows(input logic [1:0] m);
      int   last_k;
      row_t r;
      last_k = -1;
      for (int k = 0; k < 16; k++) if (tb_qual(model[k], m)) last_k = k;
      for (int k = 0; k < 16; k++) begin
         if (tb_qual(model[k], m)) begin
            r.idx  = k[3:0];
            r.val  = model[k];
            r.last = (k == last_k);
            sq.push_back(r);
         end
      end
   endtask

   task automatic run_sweep(input logic [1:0] m, input int exp_cnt, input int exp_cyc, input bit try_load);
      int cyc;
      bit seen;
      push_rows(m);
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = m;
      @(negedge clk);
      bus.start = 1'b0;
      check_eq("busy_in_sweep", 32'(bus.busy), 32'd1);
      check_eq("load_ready_in_sweep", 32'(bus.load_ready), 32'd0);
      if (try_load) begin
         bus.load_valid = 1'b1;
         bus.load_data  = 16'hFFFF;
      end
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 300) begin
         @(negedge clk);
         cyc++;
         bus.load_valid = 1'b0;
         if (bus.done) seen = 1'b1;
      end
      check_eq("done_seen", 32'(seen), 32'd1);
      if (exp_cyc > 0) check_eq("done_latency", 32'(cyc), 32'(exp_cyc));
      check_eq("count", 32'(bus.count), 32'(exp_cnt));
      check_eq("scoreboard_empty", 32'(sq.size()), 32'd0);
      @(negedge clk);
      check_eq("done_one_cycle", 32'(bus.done), 32'd0);
      check_eq("busy_after_done", 32'(bus.busy), 32'd0);
   endtask

   task automatic load_table(input logic [15:0] d);
      @(negedge clk);
      check_eq("load_ready_idle", 32'(bus.load_ready), 32'd1);
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      @(negedge clk);
      bus.load_valid = 1'b0;
      model = d;
   endtask

   initial begin
      int wait_cyc;
      bus.load_valid = 1'b0;
      bus.load_data  = 16'h0000;
      bus.eval_in    = 4'd0;
      bus.start      = 1'b0;
      bus.mode       = 2'b00;
      model          = INIT;

      repeat (3) @(negedge clk);
      check_eq("rst_out_valid",  32'(bus.out_valid),  32'd0);
      check_eq("rst_done",       32'(bus.done),       32'd0);
      check_eq("rst_count",      32'(bus.count),      32'd0);
      check_eq("rst_busy",       32'(bus.busy),       32'd0);
      check_eq("rst_load_ready", 32'(bus.load_ready), 32'd0);
      check_eq("rst_eval_out",   32'(bus.eval_out),   32'd0);
      rst = 1'b0;
      @(negedge clk);

      bus.eval_in = 4'd5;
      @(negedge clk);
      check_eq("eval_init_5", 32'(bus.eval_out), 32'd1);
      bus.eval_in = 4'd4;
      @(negedge clk);
      check_eq("eval_init_4", 32'(bus.eval_out), 32'd0);

      run_sweep(2'b01, 7, 17, 1'b0);
      run_sweep(2'b10, 9, 17, 1'b0);
      run_sweep(2'b00, 16, 17, 1'b0);
      run_sweep(2'b11, 16, 17, 1'b0);

      stall_en  = 1'b1;
      stall_cnt = 0;
      run_sweep(2'b01, 7, 20, 1'b0);
      check_eq("stall_cycles", 32'(stall_cnt), 32'd3);
      stall_en = 1'b0;

      load_table(16'h0000);
      rows_seen = 0;
      run_sweep(2'b01, 0, 17, 1'b0);
      check_eq("empty_sweep_rows", 32'(rows_seen), 32'd0);

      // Load and eval on the same edge: eval sees the old table first.
      @(negedge clk);
      check_eq("load_ready_idle2", 32'(bus.load_ready), 32'd1);
      bus.load_valid = 1'b1;
      bus.load_data  = 16'h8001;
      bus.eval_in    = 4'd0;
      @(negedge clk);
      bus.load_valid = 1'b0;
      model = 16'h8001;
      check_eq("eval_preload", 32'(bus.eval_out), 32'd0);
      @(negedge clk);
      check_eq("eval_postload", 32'(bus.eval_out), 32'd1);
      bus.eval_in = 4'd15;
      @(negedge clk);
      check_eq("eval_8001_15", 32'(bus.eval_out), 32'd1);
      bus.eval_in = 4'd14;
      @(negedge clk);
      check_eq("eval_8001_14", 32'(bus.eval_out), 32'd0);

      run_sweep(2'b00, 16, 17, 1'b1);
      bus.eval_in = 4'd7;
      @(negedge clk);
      check_eq("eval_after_blocked_load", 32'(bus.eval_out), 32'd0);

      // Abort a sweep with reset right after the third row is accepted.
      push_rows(2'b00);
      rows_seen = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = 2'b00;
      @(negedge clk);
      bus.start = 1'b0;
      wait_cyc  = 0;
      while (rows_seen < 3 && wait_cyc < 100) begin
         @(negedge clk);
         wait_cyc++;
      end
      check_eq("third_row_reached", 32'(rows_seen), 32'd3);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("abort_busy",      32'(bus.busy),      32'd0);
      check_eq("abort_done",      32'(bus.done),      32'd0);
      sq.delete();
      model = INIT;
      @(negedge clk);
      @(negedge clk);
      check_eq("abort_no_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run_sweep(2'b01, 7, 17, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
